// File: rtl/lut_neuron_bank.sv
// Bank of runtime-writable truth-table neurons with a one-deep registered stream output.
// Optional table readback port enabled by defining LUT_READBACK_EN.
module lut_neuron_bank #(
    parameter int N_NEURONS   = 4,
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 1,
    parameter int NEURON_BITS = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_we,
    output logic                          cfg_ready,
    input  logic [NEURON_BITS-1:0]        cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_wdata,
`ifdef LUT_READBACK_EN
    input  logic                          cfg_re,
    output logic                          cfg_rvalid,
    output logic [OUT_BITS-1:0]           cfg_rdata,
    output logic                          cfg_rbusy,
`endif
    output logic                          busy
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam logic [IN_BITS:0] CLR_LAST = (IN_BITS + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                          state;
    state_t                          next_state;
    logic [IN_BITS:0]                clr_addr;
    logic [IN_BITS:0]                next_clr_addr;
    logic                            in_fire;
    logic                            cfg_fire;
    logic [N_NEURONS*OUT_BITS-1:0]   lookup;
    logic [OUT_BITS-1:0]             tables [N_NEURONS][DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= next_state;
            clr_addr <= next_clr_addr;
        end
    end

    always_comb begin
        next_state    = state;
        next_clr_addr = clr_addr;
        case (state)
            CLEAR: begin
                next_clr_addr = clr_addr + 1'b1;
                if (clr_addr == CLR_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                next_state = RUN;
            end
        endcase
    end

    assign busy      = (state == CLEAR);
    assign cfg_ready = (state == RUN);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign cfg_fire  = cfg_we && cfg_ready;

    // Clearing and config writes share the single write port; out-of-range neurons match no table.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_NEURONS; k++) begin
            if (busy) begin
                tables[k][clr_addr[IN_BITS-1:0]] <= '0;
            end else if (cfg_fire && (int'(cfg_neuron) == k)) begin
                tables[k][cfg_addr] <= cfg_wdata;
            end
        end
    end

    always_comb begin
        lookup = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            lookup[k*OUT_BITS +: OUT_BITS] = tables[k][in_data[k*IN_BITS +: IN_BITS]];
        end
    end

    // The lookup reads the tables before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LUT_READBACK_EN
    logic [OUT_BITS-1:0] rd_sel;
    logic                rd_fire;

    assign rd_fire   = cfg_re && cfg_ready && !cfg_we;
    assign cfg_rbusy = busy;

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (int'(cfg_neuron) == k) begin
                rd_sel = tables[k][cfg_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            cfg_rvalid <= rd_fire;
            if (rd_fire) begin
                cfg_rdata <= rd_sel;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Randomized self-checking bench for lut_neuron_bank against a table-array reference model.
module tb_lut_neuron_bank;

    localparam int NN    = 4;
    localparam int IB    = 8;
    localparam int OB    = 1;
    localparam int NB    = 3;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NN*IB-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NN*OB-1:0] out_data;
    logic             cfg_we;
    logic             cfg_ready;
    logic [NB-1:0]    cfg_neuron;
    logic [IB-1:0]    cfg_addr;
    logic [OB-1:0]    cfg_wdata;
    logic             busy;
`ifdef LUT_READBACK_EN
    logic             cfg_re;
    logic             cfg_rvalid;
    logic [OB-1:0]    cfg_rdata;
    logic             cfg_rbusy;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit model_tab [NN][DEPTH];

    lut_neuron_bank #(
        .N_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB), .NEURON_BITS(NB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef LUT_READBACK_EN
        .cfg_re(cfg_re), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_rbusy(cfg_rbusy),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        cfg_we     = 1'b0;
        cfg_neuron = '0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
`ifdef LUT_READBACK_EN
        cfg_re     = 1'b0;
`endif
    endtask

    function automatic logic [NN*OB-1:0] model_lookup(input logic [NN*IB-1:0] d);
        logic [NN*OB-1:0] r;
        for (int k = 0; k < NN; k++) r[k] = model_tab[k][d[k*IB +: IB]];
        return r;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NN; k++)
            for (int a = 0; a < DEPTH; a++) model_tab[k][a] = 1'b0;
    endfunction

    task automatic cfg_write(input int n, input int a, input bit v);
        cfg_we     = 1'b1;
        cfg_neuron = NB'(n);
        cfg_addr   = IB'(a);
        cfg_wdata  = v;
        tick();
        if (n < NN) model_tab[n][a] = v;
        cfg_we = 1'b0;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        int cyc;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_out: out_valid=%b out_data=%h expected 0/0", out_valid, out_data);
        end
        n_checks++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL reset_ctl: in_ready=%b cfg_ready=%b busy=%b expected 0 0 1", in_ready, cfg_ready, busy);
        end
`ifdef LUT_READBACK_EN
        n_checks++;
        if (cfg_rvalid !== 1'b0 || cfg_rdata !== '0 || cfg_rbusy !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL reset_rb: rvalid=%b rdata=%h rbusy=%b expected 0 0 1", cfg_rvalid, cfg_rdata, cfg_rbusy);
        end
`endif
        rst = 1'b0;
        wait_clear(cyc);
        model_clear();
        n_checks++;
        if (cyc != DEPTH) begin
            n_errors++;
            $display("[TB] FAIL clear_len: busy cycles=%0d expected %0d", cyc, DEPTH);
        end
        n_checks++;
        if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL run_ready: in_ready=%b cfg_ready=%b expected 1 1", in_ready, cfg_ready);
        end
    endtask

    task automatic test_clear_lookup;
        in_valid  = 1'b1;
        in_data   = 32'h38383838;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0000) begin
            n_errors++;
            $display("[TB] FAIL clear_lookup: valid=%b data=%b expected 1 0000", out_valid, out_data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL clear_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stream;
        logic [NN*OB-1:0] exp;
        cfg_write(0, 'h1C, 1'b1);
        cfg_write(0, 'h38, 1'b1);
        cfg_write(0, 'h3F, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h0000003F;
        exp       = model_lookup(in_data);
        tick();
        in_data = 32'h00000001;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            n_errors++;
            $display("[TB] FAIL stream_first: valid=%b data=%b expected 1 %b", out_valid, out_data, exp);
        end
        exp = model_lookup(in_data);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            n_errors++;
            $display("[TB] FAIL stream_second: valid=%b data=%b expected 1 %b", out_valid, out_data, exp);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL stream_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_pressure;
        logic [NN*IB-1:0] a;
        logic [NN*IB-1:0] b;
        logic [NN*OB-1:0] ea;
        logic [NN*OB-1:0] eb;
        a = $urandom;
        b = $urandom;
        for (int k = 0; k < NN; k++) begin
            cfg_write(k, int'(a[k*IB +: IB]), 1'($urandom_range(0, 1)));
            cfg_write(k, int'(b[k*IB +: IB]), 1'($urandom_range(0, 1)));
        end
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = a;
        ea        = model_lookup(a);
        tick();
        in_data = b;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL bp_ready[%0d]: in_ready=%b expected 0", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ea) begin
                n_errors++;
                $display("[TB] FAIL bp_hold[%0d]: valid=%b data=%b expected 1 %b", i, out_valid, out_data, ea);
            end
        end
        out_ready = 1'b1;
        eb        = model_lookup(b);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL bp_release: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== eb) begin
            n_errors++;
            $display("[TB] FAIL bp_next: valid=%b data=%b expected 1 %b", out_valid, out_data, eb);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL bp_nodup: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_collision;
        logic [NN*OB-1:0] exp;
        cfg_write(2, 'h55, 1'b0);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        in_data    = 32'h00550000;
        cfg_we     = 1'b1;
        cfg_neuron = NB'(2);
        cfg_addr   = 8'h55;
        cfg_wdata  = 1'b1;
        exp        = model_lookup(in_data);
        tick();
        model_tab[2]['h55] = 1'b1;
        cfg_we = 1'b0;
        n_checks++;
        if (out_data !== exp || out_data[2] !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL collision_old: data=%b expected %b", out_data, exp);
        end
        exp = model_lookup(in_data);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== exp || out_data[2] !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL collision_new: data=%b expected %b", out_data, exp);
        end
        tick();
    endtask

    task automatic test_invalid_write;
        logic [NN*OB-1:0] exp;
        for (int k = 0; k < NN; k++) cfg_write(k, 'h10, 1'b0);
        for (int n = NN; n < (1 << NB); n++) begin
            cfg_we     = 1'b1;
            cfg_neuron = NB'(n);
            cfg_addr   = 8'h10;
            cfg_wdata  = 1'b1;
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL invalid_ready[%0d]: cfg_ready=%b expected 1", n, cfg_ready);
            end
            tick();
        end
        cfg_we    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h10101010;
        exp       = model_lookup(in_data);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== exp) begin
            n_errors++;
            $display("[TB] FAIL invalid_nochange: data=%b expected %b", out_data, exp);
        end
        tick();
    endtask

    task automatic test_random;
        bit               exp_valid = 1'b0;
        logic [NN*OB-1:0] exp_data  = '0;
        logic [NN*OB-1:0] nxt;
        bit               accept;
        int               wn;
        int               wa;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < NN; k++) in_data[k*IB +: IB] = 8'($urandom_range(0, 15));
            cfg_we     = 1'($urandom_range(0, 1));
            wn         = int'($urandom_range(0, 7));
            wa         = int'($urandom_range(0, 15));
            cfg_neuron = NB'(wn);
            cfg_addr   = IB'(wa);
            cfg_wdata  = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                n_errors++;
                $display("[TB] FAIL rand_ready[%0d]: in_ready=%b expected %b", i, in_ready, (!exp_valid || out_ready));
            end
            accept = in_valid && (!exp_valid || out_ready);
            nxt    = model_lookup(in_data);
            if (cfg_we && wn < NN) model_tab[wn][wa] = cfg_wdata[0];
            if (accept) begin
                exp_valid = 1'b1;
                exp_data  = nxt;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            tick();
            n_checks++;
            if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin
                n_errors++;
                $display("[TB] FAIL rand_out[%0d]: valid=%b data=%b expected %b %b", i, out_valid, out_data, exp_valid, exp_data);
            end
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
    endtask

`ifdef LUT_READBACK_EN
    task automatic test_readback;
        int a;
        a = int'($urandom_range(0, DEPTH - 2));
        cfg_write(3, a, 1'b1);
        cfg_write(3, a + 1, 1'b0);
        for (int j = 0; j < 2; j++) begin
            cfg_re     = 1'b1;
            cfg_neuron = NB'(3);
            cfg_addr   = IB'(a + j);
            tick();
            cfg_re = 1'b0;
            n_checks++;
            if (cfg_rvalid !== 1'b1 || cfg_rdata !== OB'(model_tab[3][a + j])) begin
                n_errors++;
                $display("[TB] FAIL readback[%0d]: rvalid=%b rdata=%b expected 1 %b", j, cfg_rvalid, cfg_rdata, model_tab[3][a + j]);
            end
            tick();
            n_checks++;
            if (cfg_rvalid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL readback_pulse[%0d]: rvalid=%b expected 0", j, cfg_rvalid);
            end
        end
        cfg_re = 1'b1;
        cfg_write(3, a, 1'b0);
        cfg_re = 1'b0;
        n_checks++;
        if (cfg_rvalid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL readback_wewins: rvalid=%b expected 0", cfg_rvalid);
        end
    endtask
`endif

    task automatic test_mid_reset;
        int               cyc;
        logic [NN*OB-1:0] exp;
        cfg_write(0, 'h3F, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h0000003F;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== model_lookup(32'h0000003F)) begin
            n_errors++;
            $display("[TB] FAIL midrst_pre: valid=%b data=%b expected 1 0001", out_valid, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL midrst_async: valid=%b busy=%b in_ready=%b expected 0 1 0", out_valid, busy, in_ready);
        end
        tick();
        rst = 1'b0;
        wait_clear(cyc);
        model_clear();
        n_checks++;
        if (cyc != DEPTH) begin
            n_errors++;
            $display("[TB] FAIL midrst_clear: busy cycles=%0d expected %0d", cyc, DEPTH);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h3F3F3F3F;
        exp       = model_lookup(in_data);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            n_errors++;
            $display("[TB] FAIL midrst_lookup: valid=%b data=%b expected 1 %b", out_valid, out_data, exp);
        end
`ifdef LUT_READBACK_EN
        cfg_re     = 1'b1;
        cfg_neuron = '0;
        cfg_addr   = 8'h3F;
        tick();
        cfg_re = 1'b0;
        n_checks++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== '0) begin
            n_errors++;
            $display("[TB] FAIL midrst_readback: rvalid=%b rdata=%b expected 1 0", cfg_rvalid, cfg_rdata);
        end
`endif
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        $display("[TB] starting lut_neuron_bank bench");
        test_reset();
        test_clear_lookup();
        test_stream();
        test_back_pressure();
        test_collision();
        test_invalid_write();
        test_random();
`ifdef LUT_READBACK_EN
        test_readback();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
